// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      DISCARD
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO of fetched words; head is read straight from the entry registers.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int QDEPTH = 2,
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output entry_t        head
);

   entry_t        mem [QDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Pointers wrap naturally because the depth is a power of two.
   assign do_push = push && (count < CW'(QDEPTH));
   assign do_pop  = pop && (count != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight and squashes it on redirect.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                QDEPTH   = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o,
   input  logic               instr_ready_i
);

   localparam int CW = $clog2(QDEPTH) + 1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] fetch_pc_nxt;
   logic [CW-1:0]     count;
   logic              granted;
   logic              push;
   logic              pop;
   entry_t            push_data;
   entry_t            head;

   // Only request when a queue slot is guaranteed for the single in-flight word.
   assign imem_req_o  = rst_i && (state == REQ) && (count < CW'(QDEPTH));
   assign imem_addr_o = fetch_pc;
   assign granted     = imem_req_o && imem_gnt_i;

   assign instr_valid_o = (count != '0);
   assign pop           = instr_valid_o && instr_ready_i;
   assign instr_o       = head.instr;
   assign instr_pc_o    = head.pc;

   // fetch_pc already advanced at grant, so the in-flight word sits one step behind it.
   assign push_data = '{pc: fetch_pc - PC_INC, instr: imem_rdata_i};

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= REQ;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      push         = 1'b0;
      case (state)
         REQ: begin
            if (granted) begin
               state_nxt    = WAIT;
               fetch_pc_nxt = fetch_pc + PC_INC;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               push      = 1'b1;
               state_nxt = REQ;
            end
         end
         DISCARD: begin
            if (imem_rvalid_i) state_nxt = REQ;
         end
         default: state_nxt = REQ;
      endcase

      // A redirect wins: any response still owed must be swallowed in DISCARD.
      if (redirect_i) begin
         push         = 1'b0;
         fetch_pc_nxt = {redirect_pc_i[ADDR_W-1:2], 2'b00};
         if (((state == WAIT || state == DISCARD) && !imem_rvalid_i) ||
             ((state == REQ) && granted))
            state_nxt = DISCARD;
         else
            state_nxt = REQ;
      end
   end

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_i),
      .count     (count),
      .head      (head)
   );

   rvalid_in_req : assert property (@(posedge clk_i) disable iff (!rst_i)
      !((state == REQ) && imem_rvalid_i));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model plus scoreboard of expected decoder-side entries.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          QDEPTH   = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t        exp_q[$];
   logic        outstanding = 1'b0;
   logic        squash = 1'b0;
   logic [31:0] out_addr = '0;
   logic [31:0] out_pc = '0;
   logic [31:0] exp_pc = RESET_PC;
   int          lat_left = 0;
   int          resp_lat = 1;
   int          gnt_hold = 0;
   int          pops = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instr_valid_o (instr_valid),
      .instr_o       (instr),
      .instr_pc_o    (instr_pc),
      .instr_ready_i (instr_ready)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
   endfunction

   // Mid-cycle: answer the memory handshake and keep the scoreboard in step.
   task automatic model_step();
      logic was_out;
      exp_t e;
      if (!rst) begin
         outstanding = 1'b0;
         squash      = 1'b0;
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
         exp_pc      = RESET_PC;
         exp_q.delete();
         return;
      end
      n_tests++;
      if (instr_valid !== (exp_q.size() != 0)) begin
         n_fail++;
         $display("FAIL valid_vs_queue: instr_valid_o=%b, expected entries=%0d", instr_valid, exp_q.size());
      end
      if (instr_valid && instr_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         pops++;
         n_tests++;
         if (instr_pc !== e.pc || instr !== e.instr) begin
            n_fail++;
            $display("FAIL head: pc=%h instr=%h, expected pc=%h instr=%h", instr_pc, instr, e.pc, e.instr);
         end
      end
      if (redirect) exp_q.delete();
      was_out     = outstanding;
      imem_rvalid = 1'b0;
      if (outstanding) begin
         if (lat_left == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(out_addr);
            if (!squash && !redirect) exp_q.push_back('{pc: out_pc, instr: mem_data(out_pc)});
            outstanding = 1'b0;
         end else begin
            lat_left--;
         end
      end
      imem_gnt = 1'b0;
      if (imem_req && !was_out) begin
         n_tests++;
         if (imem_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL req_addr: imem_addr_o=%h, expected %h", imem_addr, exp_pc);
         end
         if (gnt_hold > 0) begin
            gnt_hold--;
         end else begin
            imem_gnt    = 1'b1;
            outstanding = 1'b1;
            out_addr    = imem_addr;
            out_pc      = exp_pc;
            lat_left    = resp_lat - 1;
            squash      = 1'b0;
         end
      end else if (imem_req) begin
         n_tests++;
         n_fail++;
         $display("FAIL second_outstanding: imem_req_o=1 while a response is owed");
      end
      if (redirect) begin
         exp_pc = {redirect_pc[31:2], 2'b00};
         if (outstanding) squash = 1'b1;
      end else if (imem_gnt) begin
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_tests++;
      if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 ||
          instr !== 32'h0 || instr_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset: req=%b addr=%h valid=%b instr=%h pc=%h, expected 0 %h 0 0 0",
                  imem_req, imem_addr, instr_valid, instr, instr_pc, RESET_PC);
      end
   endtask

   task automatic test_first_fetch();
      instr_ready = 1'b1;
      rst = 1'b1;
      #1;
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL first_req: req=%b addr=%h valid=%b, expected 1 00000000 0", imem_req, imem_addr, instr_valid);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL cycle2_req: req=%b, expected 0", imem_req);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL cycle3: req=%b addr=%h valid=%b pc=%h, expected 1 00000004 1 00000000",
                  imem_req, imem_addr, instr_valid, instr_pc);
      end
      tick();
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         n_fail++;
         $display("FAIL cycle5: req=%b addr=%h, expected 1 00000008", imem_req, imem_addr);
      end
   endtask

   task automatic test_gnt_delay();
      gnt_hold = 3;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL gnt_hold_%0d: req=%b addr=%h, expected 1 00000008", i, imem_req, imem_addr);
         end
         tick();
      end
      n_tests++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL gnt_wait: req=%b, expected 0", imem_req);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
         n_fail++;
         $display("FAIL gnt_no_skip: req=%b addr=%h valid=%b pc=%h, expected 1 0000000c 1 00000008",
                  imem_req, imem_addr, instr_valid, instr_pc);
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 5) begin
            n_tests++;
            if (imem_req !== 1'b0) begin
               n_fail++;
               $display("FAIL full_req_%0d: req=%b, expected 0", i, imem_req);
            end
         end
      end
      n_tests++;
      if (exp_q.size() != QDEPTH || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full_count: entries=%0d valid=%b, expected %0d 1", exp_q.size(), instr_valid, QDEPTH);
      end
      instr_ready = 1'b1;
      n_tests++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL pop_cycle_req: req=%b, expected 0", imem_req);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL after_pop_req: req=%b, expected 1", imem_req);
      end
   endtask

   task automatic test_redirect_wait();
      bit found = 0;
      resp_lat = 3;
      for (int i = 0; i < 30 && !found; i++) begin
         if (imem_req) found = 1;
         else tick();
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL rw_timeout: no request seen, expected one within 30 cycles");
      end
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      n_tests++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_r1: valid=%b req=%b, expected 0 0", instr_valid, imem_req);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_discard_req: req=%b, expected 0", imem_req);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL rw_new_req: req=%b addr=%h, expected 1 00000100", imem_req, imem_addr);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid) found = 1;
         else tick();
      end
      n_tests++;
      if (!found || instr_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL rw_first_pc: valid=%b pc=%h, expected 1 00000100", instr_valid, instr_pc);
      end
      resp_lat = 1;
   endtask

   task automatic test_redirect_pop();
      bit found = 0;
      int pops_before;
      instr_ready = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (instr_valid && outstanding && lat_left == 0) found = 1;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL rp_timeout: no valid head with response due, expected one within 30 cycles");
      end
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      pops_before = pops;
      tick();
      redirect = 1'b0;
      n_tests++;
      if (pops != pops_before + 1 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL rp_r1: pops=%0d valid=%b req=%b addr=%h, expected %0d 0 1 00000300",
                  pops - pops_before, instr_valid, imem_req, imem_addr, 1);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid) found = 1;
         else tick();
      end
      n_tests++;
      if (!found || instr_pc !== 32'h300) begin
         n_fail++;
         $display("FAIL rp_first_pc: valid=%b pc=%h, expected 1 00000300", instr_valid, instr_pc);
      end
   endtask

   task automatic test_pc_wrap();
      bit found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (imem_req) found = 1;
         else tick();
      end
      gnt_hold    = 1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      n_tests++;
      if (!found || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_req: req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
      end
      tick();
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_next: req=%b addr=%h valid=%b pc=%h, expected 1 00000000 1 fffffffc",
                  imem_req, imem_addr, instr_valid, instr_pc);
      end
   endtask

   task automatic test_back_to_back();
      int pops_before = pops;
      for (int i = 0; i < 400; i++) begin
         instr_ready = 1'($urandom_range(0, 1));
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = $urandom();
         resp_lat    = $urandom_range(1, 3);
         if (gnt_hold == 0 && $urandom_range(0, 3) == 0) gnt_hold = $urandom_range(1, 2);
         tick();
      end
      redirect    = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      n_tests++;
      if (instr_valid !== 1'b0 && !imem_req) begin
         n_fail++;
         $display("FAIL drain: valid=%b req=%b, expected queue drained and fetching", instr_valid, imem_req);
      end
      n_tests++;
      if (pops - pops_before < 50) begin
         n_fail++;
         $display("FAIL throughput: pops=%0d, expected at least 50", pops - pops_before);
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_gnt_delay();
      test_backpressure();
      test_redirect_wait();
      test_redirect_pop();
      test_pc_wrap();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
